// File: rtl/mem_dump_reader.sv
// mem_dump_reader: streams a contiguous, possibly wrapping, memory address range out over a valid/ready port.
// Define DUMP_CHECKSUM_EN to append a modulo-sum beat after the last data word.
module mem_dump_reader #(
  parameter int unsigned INSTR_SIZE = 12,
  parameter int unsigned ADDR_SIZE  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_SIZE-1:0]  start_addr,
  input  logic [ADDR_SIZE-1:0]  end_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  input  logic [INSTR_SIZE-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_SIZE-1:0] out_data,
  output logic [ADDR_SIZE-1:0]  out_addr,
  output logic                  out_last
);

  typedef enum logic [2:0] {
    st_idle,
    st_issue,
    st_capture,
    st_send,
`ifdef DUMP_CHECKSUM_EN
    st_csum,
`endif
    st_done
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ADDR_SIZE-1:0] cur_addr;
  logic [ADDR_SIZE-1:0] end_q;
  logic                 at_end;
  logic                 xfer;
`ifdef DUMP_CHECKSUM_EN
  logic [INSTR_SIZE-1:0] csum;
`endif

  assign at_end   = (cur_addr == end_q);
  assign xfer     = out_valid && out_ready;
  // The address counter only moves between beats, so it doubles as the read address.
  assign mem_addr = cur_addr;

  always_ff @(posedge clk) begin
    if (rst) state_q <= st_idle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle:    if (start) state_d = st_issue;
      st_issue:   state_d = st_capture;
      st_capture: state_d = st_send;
      st_send: begin
        if (xfer) begin
          if (!at_end) state_d = st_issue;
`ifdef DUMP_CHECKSUM_EN
          else         state_d = st_csum;
`else
          else         state_d = st_done;
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      st_csum:    if (xfer) state_d = st_done;
`endif
      st_done:    state_d = st_idle;
      default:    state_d = st_idle;
    endcase
  end

  // Registered outputs and datapath, steered by the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      cur_addr  <= '0;
      end_q     <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      busy      <= (state_d != st_idle) && (state_d != st_done);
      done      <= (state_d == st_done);
      mem_rd_en <= (state_d == st_issue);
`ifdef DUMP_CHECKSUM_EN
      out_valid <= (state_d == st_send) || (state_d == st_csum);
`else
      out_valid <= (state_d == st_send);
`endif
      case (state_q)
        st_idle: begin
          if (start) begin
            cur_addr <= start_addr;
            end_q    <= end_addr;
`ifdef DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        st_capture: begin
          out_data <= mem_rd_data;
          out_addr <= cur_addr;
`ifdef DUMP_CHECKSUM_EN
          out_last <= 1'b0;
`else
          out_last <= at_end;
`endif
        end
        st_send: begin
          if (xfer) begin
            out_last <= 1'b0;
            if (!at_end) cur_addr <= ADDR_SIZE'(cur_addr + 1'b1);
`ifdef DUMP_CHECKSUM_EN
            csum <= INSTR_SIZE'(csum + out_data);
            // Checksum beat includes the word just transferred.
            if (at_end) begin
              out_data <= INSTR_SIZE'(csum + out_data);
              out_addr <= end_q;
              out_last <= 1'b1;
            end
`endif
          end
        end
`ifdef DUMP_CHECKSUM_EN
        st_csum: if (xfer) out_last <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: queue-based beat model, directed cases and randomized dumps.
// Honours DUMP_CHECKSUM_EN the same way as the design.
module tb_mem_dump_reader;
  localparam int unsigned IW    = 12;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam int CSB = 1;
`else
  localparam int CSB = 0;
`endif

  typedef struct {
    logic [IW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;

  mem_dump_reader #(.INSTR_SIZE(IW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Memory: synchronous read, data meaningful only the cycle after a strobe.
  logic [IW-1:0] mem [DEPTH];
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : IW'($urandom);

  int rdy_mode = 0;  // 0: always ready, 1: random, other: held low
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  beat_t expq[$];
  beat_t logq[$];

  // Expected beats straight from the range rules: walk s..e modulo depth.
  function automatic void push_dump(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] a;
    logic [IW-1:0] sum;
    beat_t b;
    a = s;
    sum = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      b.data = mem[a]; b.addr = a; b.last = 1'b0;
      expq.push_back(b);
      sum = IW'(sum + mem[a]);
      if (a == e) break;
      a = AW'(a + 1);
    end
`ifdef DUMP_CHECKSUM_EN
    b.data = sum; b.addr = e; b.last = 1'b1;
    expq.push_back(b);
`else
    b = expq.pop_back();
    b.last = 1'b1;
    expq.push_back(b);
`endif
  endfunction

  int   first_due     = 0;
  bit   waiting_first = 1'b0;
  int   done_cnt      = 0;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [IW-1:0] pd = '0;
  logic [AW-1:0] pa = '0;

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t b, g;
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data",  32'(out_data),  32'(pd));
        chk("hold_addr",  32'(out_addr),  32'(pa));
        chk("hold_last",  32'(out_last),  32'(pl));
      end
      if (out_valid) begin
        chk("busy_in_beat", 32'(busy), 32'd1);
        if (waiting_first) begin
          chk("first_latency", 32'(cyc), 32'(first_due));
          waiting_first = 1'b0;
        end
      end
      if (out_valid && out_ready) begin
        g.data = out_data; g.addr = out_addr; g.last = out_last;
        logq.push_back(g);
        if (expq.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = expq.pop_front();
          chk("beat_data", 32'(out_data), 32'(b.data));
          chk("beat_addr", 32'(out_addr), 32'(b.addr));
          chk("beat_last", 32'(out_last), 32'(b.last));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_drained", 32'(expq.size()), 32'd0);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr; pl = out_last;
    end
  end

  task automatic start_dump(input logic [AW-1:0] s, input logic [AW-1:0] e);
    push_dump(s, e);
    start = 1'b1; start_addr = s; end_addr = e;
    first_due = cyc + 3;
    waiting_first = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_addr = AW'($urandom); end_addr = AW'($urandom);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    int d0;
    logic [AW-1:0] s, e;
    rst = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = IW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word
    mem[0] = 12'hA05;
    base = logq.size();
    start_dump(5'd0, 5'd0);
    wait_done(200, "single");
    chk("single_count", 32'(logq.size() - base), 32'(1 + CSB));
    chk("single_data", 32'(logq[base].data), 32'h A05);
    chk("single_addr", 32'(logq[base].addr), 32'd0);
    chk("single_last", 32'(logq[base].last), 32'(1 - CSB));

    // Range 1..3
    mem[1] = 12'hC11; mem[2] = 12'hE0E; mem[3] = 12'h111;
    base = logq.size();
    start_dump(5'd1, 5'd3);
    wait_done(200, "range");
    chk("range_count", 32'(logq.size() - base), 32'(3 + CSB));
    chk("range_d1", 32'(logq[base+1].data), 32'h E0E);
    chk("range_a2", 32'(logq[base+2].addr), 32'd3);
    chk("range_l1", 32'(logq[base+1].last), 32'd0);
    chk("range_l2", 32'(logq[base+2].last), 32'(1 - CSB));
`ifdef DUMP_CHECKSUM_EN
    chk("range_csum", 32'(logq[base+3].data), 32'h B30);
`endif

    // Backpressure on the second beat
    base = logq.size();
    start_dump(5'd1, 5'd3);
    n = 0;
    while (logq.size() < base + 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    rdy_mode = 2;
    wait_valid(50, "bp");
    repeat (5) @(posedge clk);
    #1;
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", 32'(out_data), 32'h E0E);
    chk("bp_addr", 32'(out_addr), 32'd2);
    rdy_mode = 0;
    wait_done(200, "bp");
    chk("bp_count", 32'(logq.size() - base), 32'(3 + CSB));

    // Wrap 30..1
    mem[30] = 12'd1; mem[31] = 12'd2; mem[0] = 12'd3; mem[1] = 12'd4;
    base = logq.size();
    start_dump(5'd30, 5'd1);
    wait_done(300, "wrap");
    chk("wrap_count", 32'(logq.size() - base), 32'(4 + CSB));
    chk("wrap_a1", 32'(logq[base+1].addr), 32'd31);
    chk("wrap_a2", 32'(logq[base+2].addr), 32'd0);
    chk("wrap_d3", 32'(logq[base+3].data), 32'd4);
`ifdef DUMP_CHECKSUM_EN
    chk("wrap_csum", 32'(logq[base+4].data), 32'h00A);
    chk("wrap_csum_last", 32'(logq[base+4].last), 32'd1);
`endif

    // start while busy is ignored
    base = logq.size();
    start_dump(5'd5, 5'd8);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; start_addr = 5'd20; end_addr = 5'd21;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(300, "ignore");
    chk("ignore_count", 32'(logq.size() - base), 32'(4 + CSB));

    // start in the DONE cycle is ignored
    start_dump(5'd7, 5'd7);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    chk("donecyc_seen", 32'(done), 32'd1);
    start = 1'b1; start_addr = 5'd0; end_addr = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("donecyc_idle_busy", 32'(busy), 32'd0);
    chk("donecyc_idle_valid", 32'(out_valid), 32'd0);

    // Reset while in SEND abandons the dump
    rdy_mode = 2;
    start_dump(5'd10, 5'd12);
    wait_valid(50, "rst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    waiting_first = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_rd_en", 32'(mem_rd_en), 32'd0);
    rdy_mode = 0;
    d0 = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 32'(done_cnt), 32'(d0));
    base = logq.size();
    start_dump(5'd3, 5'd6);
    wait_done(300, "fresh");
    chk("fresh_count", 32'(logq.size() - base), 32'(4 + CSB));

    // Randomized dumps with random backpressure, including full-depth ranges
    rdy_mode = 1;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = IW'($urandom);
      s = AW'($urandom);
      e = (t < 3) ? AW'(s - 1) : AW'($urandom);
      start_dump(s, e);
      wait_done(3000, "rand");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
